seq_mult_bcd_scroll: RTL and testbench

//  Parametrised successor to the 8x8 multiplier/display path: a sequential signed shift-add multiplier feeding a sequential double-dabble BCD converter.

---
 rtl/seq_mult_pkg.sv | 16 +
 rtl/seq_mult_bcd_scroll_dabble.sv | 43 ++++
 rtl/seq_mult_bcd_scroll.sv | 152 +++++++++++++++
 tb/tb_seq_mult_bcd_scroll.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential multiplier / BCD window block.
package seq_mult_pkg;

    typedef enum logic [1:0] {IDLE, MULT, BCD, DONE} state_t;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    // Ceiling log2, never below 1 so derived port widths stay legal.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seq_mult_bcd_scroll_dabble.sv
// Sequential double-dabble engine: load latches the binary word, each step adjusts then shifts one bit.
module dabble_seq
    import seq_mult_pkg::*;
#(
    parameter int BW   = 16,
    parameter int NDIG = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic [BW-1:0]       bin,
    output logic [NDIG*4-1:0]   bcd
);

    logic [BW-1:0]      bin_reg;
    logic [NDIG*4-1:0]  bcd_reg;
    logic [NDIG*4-1:0]  bcd_adj;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                      ? bcd_reg[gi*4 +: 4] + 4'd3
                                      : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_reg <= '0;
            bcd_reg <= '0;
        end else if (load) begin
            bin_reg <= bin;
            bcd_reg <= '0;
        end else if (step) begin
            bcd_reg <= {bcd_adj[NDIG*4-2:0], bin_reg[BW-1]};
            bin_reg <= {bin_reg[BW-2:0], 1'b0};
        end
    end

    assign bcd = bcd_reg;

endmodule

// File: rtl/seq_mult_bcd_scroll.sv
// Signed shift-add multiplier feeding a sequential BCD converter, with a scrollable digit window.
// Optional LEADING_ZERO_BLANK_EN: blank window digits above the most significant nonzero digit.
module seq_mult_bcd_scroll
    import seq_mult_pkg::*;
#(
    parameter int W    = 8,
    parameter int NDIG = 5,
    parameter int WIN  = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [W-1:0]                      mp,
    input  logic [W-1:0]                      mc,
    input  logic                              scroll_l,
    input  logic                              scroll_r,
    output logic                              busy,
    output logic                              done,
    output logic                              sign,
    output logic [2*W-1:0]                    product,
    output logic [clog2(NDIG-WIN+1)-1:0]      win_pos,
    output logic [4*WIN-1:0]                  win_digits
);

    localparam int PW = clog2(NDIG-WIN+1);
    localparam int CW = clog2(2*W+1);
    localparam int IW = clog2(NDIG);
    localparam logic [PW-1:0] POS_MAX = PW'(NDIG-WIN);

    state_t              state_reg, state_next;
    logic [CW-1:0]       cnt_reg;
    logic [W-1:0]        mplier_reg;
    logic [2*W-1:0]      mcand_reg;
    logic [2*W-1:0]      acc_reg;
    logic [2*W-1:0]      acc_next;
    logic                sign_reg;
    logic [2*W-1:0]      product_reg;
    logic [NDIG*4-1:0]   digits_reg;
    logic [NDIG*4-1:0]   dabble_bcd;
    logic [PW-1:0]       pos_reg;
    logic [W-1:0]        mp_mag, mc_mag;
    logic                start_acc, mult_last, bcd_last;

    assign start_acc = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign mult_last = (state_reg == MULT) && (cnt_reg == CW'(W-1));
    assign bcd_last  = (state_reg == BCD)  && (cnt_reg == CW'(2*W));
    assign mp_mag    = mp[W-1] ? (~mp + W'(1)) : mp;
    assign mc_mag    = mc[W-1] ? (~mc + W'(1)) : mc;
    assign acc_next  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = MULT;
            MULT:    if (mult_last) state_next = BCD;
            BCD:     if (bcd_last) state_next = DONE;
            DONE:    if (start) state_next = MULT;
            default: state_next = IDLE;
        endcase
    end

    // The last multiply step loads the converter with the final sum directly,
    // so BCD spends 2W shift cycles plus one cycle to publish the result.
    dabble_seq #(.BW(2*W), .NDIG(NDIG)) u_dabble (
        .clk  (clk),
        .rst  (rst),
        .load (mult_last),
        .step ((state_reg == BCD) && !bcd_last),
        .bin  (acc_next),
        .bcd  (dabble_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= '0;
            mplier_reg  <= '0;
            mcand_reg   <= '0;
            acc_reg     <= '0;
            sign_reg    <= 1'b0;
            product_reg <= '0;
            digits_reg  <= '0;
        end else if (start_acc) begin
            cnt_reg    <= '0;
            mplier_reg <= mp_mag;
            mcand_reg  <= {{W{1'b0}}, mc_mag};
            acc_reg    <= '0;
            sign_reg   <= mp[W-1] ^ mc[W-1];
        end else begin
            case (state_reg)
                MULT: begin
                    acc_reg    <= acc_next;
                    mplier_reg <= {1'b0, mplier_reg[W-1:1]};
                    mcand_reg  <= {mcand_reg[2*W-2:0], 1'b0};
                    cnt_reg    <= mult_last ? '0 : cnt_reg + CW'(1);
                end
                BCD: begin
                    cnt_reg <= cnt_reg + CW'(1);
                    if (bcd_last) begin
                        product_reg <= sign_reg ? (~acc_reg + (2*W)'(1)) : acc_reg;
                        digits_reg  <= dabble_bcd;
                        if (acc_reg == '0) sign_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start_acc)
            pos_reg <= '0;
        else if (scroll_l && !scroll_r && (pos_reg != POS_MAX))
            pos_reg <= pos_reg + PW'(1);
        else if (scroll_r && !scroll_l && (pos_reg != '0))
            pos_reg <= pos_reg - PW'(1);
    end

    logic [3:0] shown [NDIG];

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_shown
            if (gi == 0) begin : g_lsd
                assign shown[gi] = digits_reg[3:0];
            end else begin : g_upper
`ifdef LEADING_ZERO_BLANK_EN
                assign shown[gi] = (digits_reg[NDIG*4-1:gi*4] == '0)
                                 ? BLANK_DIGIT : digits_reg[gi*4 +: 4];
`else
                assign shown[gi] = digits_reg[gi*4 +: 4];
`endif
            end
        end

        for (genvar gi = 0; gi < WIN; gi++) begin : g_win
            logic [IW-1:0] idx;
            assign idx = IW'(pos_reg) + IW'(gi);
            assign win_digits[gi*4 +: 4] = shown[idx];
        end
    endgenerate

    assign busy    = (state_reg == MULT) || (state_reg == BCD);
    assign done    = (state_reg == DONE);
    assign sign    = sign_reg;
    assign product = product_reg;
    assign win_pos = pos_reg;

endmodule

// File: tb/tb_seq_mult_bcd_scroll.sv
// Randomised scoreboard bench for seq_mult_bcd_scroll (W=8, NDIG=5, WIN=3).
module tb_seq_mult_bcd_scroll;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic signed [7:0] mp = '0;
    logic signed [7:0] mc = '0;
    logic              scroll_l = 1'b0;
    logic              scroll_r = 1'b0;
    logic              busy, done, sign;
    logic [15:0]       product;
    logic [1:0]        win_pos;
    logic [11:0]       win_digits;

    seq_mult_bcd_scroll #(.W(8), .NDIG(5), .WIN(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mp         (mp),
        .mc         (mc),
        .scroll_l   (scroll_l),
        .scroll_r   (scroll_r),
        .busy       (busy),
        .done       (done),
        .sign       (sign),
        .product    (product),
        .win_pos    (win_pos),
        .win_digits (win_digits)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] product;
        logic        sign;
        logic [11:0] win;
        int          t;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cur_mag = 0;
    int   model_pos = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Decimal digit k of a magnitude, straight from arithmetic.
    function automatic int dec_digit(input int mag, input int k);
        int p;
        p = 1;
        for (int j = 0; j < k; j++) p = p * 10;
        return (mag / p) % 10;
    endfunction

    function automatic logic [11:0] win_model(input int mag, input int pos);
        logic [11:0] r;
        int msd, d, k;
        msd = 0;
        for (int j = 0; j < 5; j++) if (dec_digit(mag, j) != 0) msd = j;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            k = pos + i;
            d = dec_digit(mag, k);
`ifdef LEADING_ZERO_BLANK_EN
            if (k > 0 && k > msd) d = 15;
`endif
            r[i*4 +: 4] = 4'(d);
        end
        return r;
    endfunction

    // Monitor: pops one expectation on every rising edge of done.
    initial begin
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_prev = 1'b0;
            end else begin
                if (done && !done_prev) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("product", product, e.product);
                        check("sign", sign, e.sign);
                        check("win_digits", win_digits, e.win);
                        check("win_pos_at_done", win_pos, 0);
                        check("latency", cyc - e.t, 25);
                    end
                end
                done_prev = done;
            end
        end
    end

    task automatic issue(input logic signed [7:0] a, input logic signed [7:0] b,
                         input logic sl, input bit push);
        exp_t e;
        int ai, bi, prod;
        @(negedge clk);
        mp = a; mc = b; start = 1'b1; scroll_l = sl;
        if (push) begin
            ai = a; bi = b;
            prod = ai * bi;
            cur_mag = (prod < 0) ? -prod : prod;
            model_pos = 0;
            e.product = 16'(prod);
            e.sign    = (prod < 0);
            e.win     = win_model(cur_mag, 0);
            e.t       = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0; scroll_l = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic scroll(input logic l, input logic r);
        @(negedge clk);
        scroll_l = l; scroll_r = r;
        @(negedge clk);
        scroll_l = 1'b0; scroll_r = 1'b0;
        if (l && !r && model_pos < 2) model_pos++;
        else if (r && !l && model_pos > 0) model_pos--;
        check("scroll_pos", win_pos, model_pos);
        check("scroll_digits", win_digits, win_model(cur_mag, model_pos));
    endtask

    initial begin
        logic signed [7:0] a, b;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sign", sign, 0);
        check("rst_product", product, 0);
        check("rst_win_pos", win_pos, 0);
        check("rst_win_digits", win_digits, win_model(0, 0));

        // 7 * -3
        issue(8'sd7, -8'sd3, 1'b0, 1'b1);
        check("busy_after_start", busy, 1);
        wait_done();
        repeat (3) @(negedge clk);
        check("done_held", done, 1);

        // -128 * -128, then scroll to the top and past it
        issue(-8'sd128, -8'sd128, 1'b0, 1'b1);
        wait_done();
        scroll(1'b1, 1'b0);
        scroll(1'b1, 1'b0);
        scroll(1'b1, 1'b0);
        scroll(1'b0, 1'b1);
        scroll(1'b1, 1'b1);

        // start together with scroll_l: start wins
        issue(8'sd0, -8'sd5, 1'b1, 1'b1);
        check("start_beats_scroll", win_pos, 0);
        wait_done();

        // a second start while busy is ignored
        issue(8'sd99, -8'sd77, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        issue(8'sd12, 8'sd13, 1'b0, 1'b0);
        check("busy_after_ignored", busy, 1);
        wait_done();

        // reset in the middle of MULT
        issue(8'sd55, 8'sd66, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_product", product, 0);
        check("abort_win_pos", win_pos, 0);
        issue(-8'sd9, 8'sd11, 1'b0, 1'b1);
        wait_done();

        for (int n = 0; n < 16; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (n == 0) a = 8'sd127;
            if (n == 1) b = -8'sd128;
            issue(a, b, 1'b0, 1'b1);
            wait_done();
            for (int s = 0; s < int'($urandom_range(0, 3)); s++)
                scroll(1'($urandom), 1'($urandom));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
